aes_uart_frame_loader: RTL and testbench

- Sits between the UART receiver and the AES datapath.
- Parses framed byte streams from UART RX into either a cipher key, which drives the key input of the key-expansion block, or a 128-bit plaintext block, which drives the cipher core.
- Each frame is one command byte followed by payload bytes, most significant byte first.
- Provides key-update pulses, a valid/ready handshake for data blocks, an inter-byte timeout and error reporting.

---
 rtl/aes_uart_frame_loader.sv | 163 ++++++++++++++++
 tb/tb_aes_uart_frame_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_uart_frame_loader.sv
// Frame parser between UART RX and the AES datapath: command byte + MSB-first payload
// is assembled into either the cipher key or a 128-bit plaintext block.
module aes_uart_frame_loader #(
    parameter int          NK             = 4,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  CMD_KEY        = 8'h4B,
    parameter logic [7:0]  CMD_DATA       = 8'h44
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [NK*32-1:0]  key,
    output logic              key_valid,
    output logic [127:0]      block,
    output logic              block_valid,
    input  logic              block_ready,
    output logic              busy,
    output logic              frame_err
);

    localparam int KW   = NK * 32;
    localparam int KB   = NK * 4;
    localparam int SW   = (KW > 128) ? KW : 128;
    localparam int MAXB = (KB > 16) ? KB : 16;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV_KEY,
        S_RECV_DATA,
        S_HOLD
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [TW-1:0]    tmo_q;
    logic [SW-1:0]    shreg_q;
    logic [KW-1:0]    key_q;
    logic             key_valid_q;
    logic [127:0]     block_q;
    logic             block_valid_q;
    logic             busy_q;
    logic             frame_err_q;

    logic [SW-1:0]    shreg_d;
    logic             timeout_hit;
    logic             last_key_byte;
    logic             last_data_byte;

    assign shreg_d        = {shreg_q[SW-9:0], rx_data};
    assign last_key_byte  = (count_q == CW'(KB - 1));
    assign last_data_byte = (count_q == CW'(15));
    // Fires on the idle cycle that would bring the counter up to the limit; a byte
    // arriving in that same cycle takes precedence.
    assign timeout_hit    = (TIMEOUT_CYCLES != 0) && !rx_valid &&
                            (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            tmo_q         <= '0;
            shreg_q       <= '0;
            key_q         <= '0;
            key_valid_q   <= 1'b0;
            block_q       <= '0;
            block_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        count_q <= '0;
                        tmo_q   <= '0;
                        shreg_q <= '0;
                        if (rx_data == CMD_KEY) begin
                            state_q <= S_RECV_KEY;
                            busy_q  <= 1'b1;
                        end else if (rx_data == CMD_DATA) begin
                            state_q <= S_RECV_DATA;
                            busy_q  <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                S_RECV_KEY: begin
                    if (rx_valid) begin
                        shreg_q <= shreg_d;
                        tmo_q   <= '0;
                        if (last_key_byte) begin
                            key_q       <= shreg_d[KW-1:0];
                            key_valid_q <= 1'b1;
                            count_q     <= '0;
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end else if (timeout_hit) begin
                        count_q     <= '0;
                        tmo_q       <= '0;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_RECV_DATA: begin
                    if (rx_valid) begin
                        shreg_q <= shreg_d;
                        tmo_q   <= '0;
                        if (last_data_byte) begin
                            block_q       <= shreg_d[127:0];
                            block_valid_q <= 1'b1;
                            count_q       <= '0;
                            state_q       <= S_HOLD;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end else if (timeout_hit) begin
                        count_q     <= '0;
                        tmo_q       <= '0;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_HOLD: begin
                    // Overrun byte is dropped, but a coincident handshake still completes.
                    if (rx_valid) begin
                        frame_err_q <= 1'b1;
                    end
                    if (block_ready) begin
                        block_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign key         = key_q;
    assign key_valid   = key_valid_q;
    assign block       = block_q;
    assign block_valid = block_valid_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_aes_uart_frame_loader.sv
// Directed bench for aes_uart_frame_loader: key/data frames, backpressure, timeout,
// bad command, overrun, mid-frame reset and back-to-back traffic.
module tb_aes_uart_frame_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic [127:0] key;
    logic         key_valid;
    logic [127:0] block;
    logic         block_valid;
    logic         block_ready = 1'b0;
    logic         busy;
    logic         frame_err;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] KEY1 = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] DAT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DAT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] DAT3 = 128'hfedcba98765432100123456789abcdef;

    aes_uart_frame_loader #(
        .NK             (4),
        .TIMEOUT_CYCLES (20),
        .CMD_KEY        (8'h4B),
        .CMD_DATA       (8'h44)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .key         (key),
        .key_valid   (key_valid),
        .block       (block),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step(1);
        rx_valid = 1'b0;
    endtask

    // Sends the top nbytes of v, most significant byte first, one per cycle.
    task automatic send_payload(input logic [127:0] v, input int nbytes);
        logic [127:0] tmp;
        tmp = v;
        for (int i = 0; i < nbytes; i++) begin
            send_byte(tmp[127:120]);
            tmp = tmp << 8;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        rst = 1'b0;
        check("rst_key", key, '0);
        check("rst_key_valid", {127'b0, key_valid}, 128'd0);
        check("rst_block", block, '0);
        check("rst_block_valid", {127'b0, block_valid}, 128'd0);
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_frame_err", {127'b0, frame_err}, 128'd0);

        // Key load
        send_byte(8'h4B);
        check("key_busy_after_cmd", {127'b0, busy}, 128'd1);
        send_payload(KEY1, 15);
        check("key_no_partial", key, '0);
        check("key_valid_early", {127'b0, key_valid}, 128'd0);
        send_payload(KEY1 << 120, 1);
        $display("key frame: key=%h key_valid=%b busy=%b", key, key_valid, busy);
        check("key1_value", key, KEY1);
        check("key1_valid_pulse", {127'b0, key_valid}, 128'd1);
        check("key1_busy_low", {127'b0, busy}, 128'd0);
        step(1);
        check("key1_valid_cleared", {127'b0, key_valid}, 128'd0);
        check("key1_held", key, KEY1);

        // Data with backpressure
        step(2);
        send_byte(8'h44);
        send_payload(DAT1, 16);
        $display("data frame: block=%h block_valid=%b", block, block_valid);
        check("dat1_valid", {127'b0, block_valid}, 128'd1);
        check("dat1_block", block, DAT1);
        check("dat1_busy_hold", {127'b0, busy}, 128'd1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("dat1_valid_held", {127'b0, block_valid}, 128'd1);
            check("dat1_block_stable", block, DAT1);
        end
        block_ready = 1'b1;
        step(1);
        block_ready = 1'b0;
        check("dat1_valid_cleared", {127'b0, block_valid}, 128'd0);
        check("dat1_busy_low", {127'b0, busy}, 128'd0);
        check("dat1_block_kept", block, DAT1);

        // Timeout: command + 3 bytes then idle
        send_byte(8'h44);
        send_payload(128'hdeadbe00_00000000_00000000_00000000, 3);
        for (int i = 0; i < 19; i++) begin
            step(1);
            check("tmo_no_err_yet", {127'b0, frame_err}, 128'd0);
            check("tmo_still_busy", {127'b0, busy}, 128'd1);
        end
        step(1);
        $display("timeout: frame_err=%b busy=%b block_valid=%b", frame_err, busy, block_valid);
        check("tmo_err_pulse", {127'b0, frame_err}, 128'd1);
        check("tmo_idle", {127'b0, busy}, 128'd0);
        check("tmo_no_block_valid", {127'b0, block_valid}, 128'd0);
        step(1);
        check("tmo_err_cleared", {127'b0, frame_err}, 128'd0);
        send_byte(8'h4B);
        send_payload(KEY2, 16);
        $display("key after timeout: key=%h", key);
        check("key2_value", key, KEY2);
        check("key2_valid", {127'b0, key_valid}, 128'd1);

        // Bad command
        step(1);
        send_byte(8'h5A);
        $display("bad cmd: frame_err=%b key=%h", frame_err, key);
        check("badcmd_err", {127'b0, frame_err}, 128'd1);
        check("badcmd_key_kept", key, KEY2);
        check("badcmd_idle", {127'b0, busy}, 128'd0);
        step(1);
        check("badcmd_err_cleared", {127'b0, frame_err}, 128'd0);

        // Overrun while holding a block
        send_byte(8'h44);
        send_payload(DAT2, 16);
        check("dat2_block", block, DAT2);
        send_byte(8'hAA);
        $display("overrun: frame_err=%b block=%h", frame_err, block);
        check("ovr_err", {127'b0, frame_err}, 128'd1);
        check("ovr_block_kept", block, DAT2);
        check("ovr_valid_kept", {127'b0, block_valid}, 128'd1);
        step(1);
        check("ovr_err_cleared", {127'b0, frame_err}, 128'd0);
        // Overrun byte coinciding with the handshake
        block_ready = 1'b1;
        send_byte(8'hBB);
        block_ready = 1'b0;
        $display("overrun+handshake: frame_err=%b block_valid=%b", frame_err, block_valid);
        check("ovr_hs_err", {127'b0, frame_err}, 128'd1);
        check("ovr_hs_valid_cleared", {127'b0, block_valid}, 128'd0);
        check("ovr_hs_idle", {127'b0, busy}, 128'd0);

        // Reset mid-frame
        step(1);
        send_byte(8'h4B);
        send_payload(128'hffeeddccbbaa9900_0000000000000000, 7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        $display("reset mid-frame: key=%h block=%h busy=%b", key, block, busy);
        check("mrst_key", key, '0);
        check("mrst_block", block, '0);
        check("mrst_busy", {127'b0, busy}, 128'd0);
        check("mrst_frame_err", {127'b0, frame_err}, 128'd0);
        check("mrst_flags", {125'b0, key_valid, block_valid, frame_err}, 128'd0);
        send_byte(8'h4B);
        send_payload(KEY3, 16);
        $display("key after reset: key=%h", key);
        check("key3_value", key, KEY3);

        // Back-to-back key then data frame, rx_valid every cycle
        send_byte(8'h4B);
        send_payload(KEY1, 16);
        check("b2b_key", key, KEY1);
        check("b2b_key_valid", {127'b0, key_valid}, 128'd1);
        send_byte(8'h44);
        check("b2b_data_busy", {127'b0, busy}, 128'd1);
        send_payload(DAT3, 16);
        $display("back-to-back: key=%h block=%h block_valid=%b", key, block, block_valid);
        check("b2b_block", block, DAT3);
        check("b2b_block_valid", {127'b0, block_valid}, 128'd1);
        block_ready = 1'b1;
        step(1);
        block_ready = 1'b0;
        check("b2b_valid_cleared", {127'b0, block_valid}, 128'd0);
        check("b2b_no_err", {127'b0, frame_err}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
